// File: rtl/xor_descrambler_pkg.sv
// Shared definitions for the XOR descrambler and its transmit-side twin.
//
// Contents:
//   LFSR_W, TAP_HI, TAP_LO : keystream LFSR geometry (x^7 + x^4 + 1)
//   fsm_state_t            : frame-sync states
//   ks_step8()             : advances the LFSR eight steps and returns
//                            {next_state, keystream_byte}. The scrambler
//                            calls this same function so both ends always
//                            produce an identical keystream.
package xor_descrambler_pkg;

    localparam int LFSR_W = 7;
    localparam int TAP_HI = 6;
    localparam int TAP_LO = 3;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } fsm_state_t;

    // Keystream bit i comes from step i, so the first step lands in the LSB.
    function automatic logic [LFSR_W+7:0] ks_step8(input logic [LFSR_W-1:0] state);
        logic [LFSR_W-1:0] s;
        logic [7:0]        ks;
        logic              k;
        s  = state;
        ks = '0;
        for (int i = 0; i < 8; i++) begin
            k     = s[TAP_HI] ^ s[TAP_LO];
            ks[i] = k;
            s     = {s[LFSR_W-2:0], k};
        end
        return {s, ks};
    endfunction

endpackage

// File: rtl/xor_descrambler_if.sv
// Byte-stream bundle around the descrambler.
//
// Handshake rule for both streams: a byte moves on a rising clock edge where
// valid and ready are both high. The producer keeps valid and its payload
// steady until that edge; ready may change freely and never depends on
// whether the transfer itself is taking place.
//
// Signals:
//   io_in_valid/io_in_ready/io_in_data/io_in_first/io_in_last : input stream
//   io_out_valid/io_out_ready/io_out_data/io_out_last         : output stream
//   io_sync_err  : one-cycle framing violation pulse
//   io_frame_cnt : frames fully delivered at the output
//   dbg_state    : current frame-sync state
//
// Modports: slave = the descrambler, master = source/consumer side.
interface xor_descrambler_if
    import xor_descrambler_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             io_in_valid;
    logic             io_in_ready;
    logic [7:0]       io_in_data;
    logic             io_in_first;
    logic             io_in_last;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [7:0]       io_out_data;
    logic             io_out_last;
    logic             io_sync_err;
    logic [CNT_W-1:0] io_frame_cnt;
    fsm_state_t       dbg_state;

    modport slave (
        input  io_in_valid, io_in_data, io_in_first, io_in_last, io_out_ready,
        output io_in_ready, io_out_valid, io_out_data, io_out_last,
               io_sync_err, io_frame_cnt, dbg_state
    );

    modport master (
        output io_in_valid, io_in_data, io_in_first, io_in_last, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_data, io_out_last,
               io_sync_err, io_frame_cnt, dbg_state
    );
endinterface

// File: rtl/xor_descrambler_lfsr.sv
// Keystream generator for the descrambler.
//
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   accept       : an input byte is consumed this cycle
//   first        : that byte starts a frame (keystream restarts from SEED)
//   ks_byte      : keystream byte for the byte currently presented
//
// The keystream is computed combinationally from either SEED or the stored
// state so the first byte of a frame needs no extra cycle.
module xor_descrambler_lfsr
    import xor_descrambler_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 7'h7F
)(
    input  logic       clock,
    input  logic       reset,
    input  logic       accept,
    input  logic       first,
    output logic [7:0] ks_byte
);
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] start;
    logic [LFSR_W+7:0] step;

    assign start   = first ? SEED : lfsr;
    assign step    = ks_step8(start);
    assign ks_byte = step[7:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (accept) begin
            lfsr <= step[LFSR_W+7:8];
        end
    end
endmodule

// File: rtl/xor_descrambler.sv
// Receive-side XOR descrambler with a one-entry output register and frame
// sync tracking.
//
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   io           : xor_descrambler_if.slave bundle (input stream, output
//                  stream, sync error pulse, delivered-frame counter, state)
//
// An input byte is taken whenever the output register is empty or is being
// drained in the same cycle, giving one byte per cycle at full rate.
module xor_descrambler
    import xor_descrambler_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = 7'h7F,
    parameter int                CNT_W = 16
)(
    input  logic                 clock,
    input  logic                 reset,
    xor_descrambler_if.slave     io
);
    logic             in_ready;
    logic             accept;
    logic             drain;
    logic [7:0]       ks_byte;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_last;
    logic             sync_err;
    logic             sync_err_next;
    logic [CNT_W-1:0] frame_cnt;
    fsm_state_t       state;
    fsm_state_t       state_next;

    assign in_ready = ~out_valid | io.io_out_ready;
    assign accept   = io.io_in_valid & in_ready;
    assign drain    = out_valid & io.io_out_ready;

    xor_descrambler_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .accept  (accept),
        .first   (io.io_in_first),
        .ks_byte (ks_byte)
    );

    // Frame sync: every accepted byte leaves us in IN_FRAME unless it carries
    // last. A byte without first in IDLE, or with first in IN_FRAME, is a
    // violation but the byte is still passed on.
    always_comb begin
        state_next    = state;
        sync_err_next = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (!io.io_in_first) begin
                        sync_err_next = 1'b1;
                    end
                    state_next = io.io_in_last ? IDLE : IN_FRAME;
                end
                IN_FRAME: begin
                    if (io.io_in_first) begin
                        sync_err_next = 1'b1;
                        state_next    = io.io_in_last ? IDLE : IN_FRAME;
                    end else if (io.io_in_last) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            sync_err  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state    <= state_next;
            sync_err <= sync_err_next;
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= io.io_in_data ^ ks_byte;
                out_last  <= io.io_in_last;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            if (drain && out_last) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign io.io_in_ready  = in_ready;
    assign io.io_out_valid = out_valid;
    assign io.io_out_data  = out_data;
    assign io.io_out_last  = out_last;
    assign io.io_sync_err  = sync_err;
    assign io.io_frame_cnt = frame_cnt;
    assign io.dbg_state    = state;

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (!reset && out_valid && io.io_out_ready) begin
            $display("xor_descrambler: out data=%02h last=%0b", out_data, out_last);
        end
    end
`endif
endmodule

// File: tb/tb_xor_descrambler.sv
module tb_xor_descrambler;
    import xor_descrambler_pkg::*;

    logic clock;
    logic reset;
    xor_descrambler_if #(.CNT_W(16)) bus ();

    xor_descrambler #(.SEED(7'h7F), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .io    (bus)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checking ----------------
    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        chk_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    // ---------------- reference model ----------------
    // Keystream as a bit sequence: b[n] = b[n-7] ^ b[n-4], seeded with the
    // SEED bits oldest-first; bytes take 8 consecutive bits LSB first.
    logic [6:0]  seed_v = 7'h7F;
    bit          hist[$];
    bit          m_in_frame;
    int          m_frames;
    bit          exp_err;
    logic [8:0]  exp_q[$];
    logic [7:0]  cap_q[$];
    logic [7:0]  last_out;
    int          err_seen;

    function automatic void model_restart();
        hist.delete();
        for (int i = 6; i >= 0; i--) hist.push_back(seed_v[i]);
    endfunction

    function automatic logic [7:0] model_ks(input bit first);
        logic [7:0] ks;
        bit b;
        if (first) model_restart();
        ks = '0;
        for (int i = 0; i < 8; i++) begin
            b = hist[hist.size()-7] ^ hist[hist.size()-4];
            hist.push_back(b);
            void'(hist.pop_front());
            ks[i] = b;
        end
        return ks;
    endfunction

    initial begin
        model_restart();
        m_in_frame = 0;
        m_frames   = 0;
        exp_err    = 0;
        err_seen   = 0;
        last_out   = '0;
    end

    // Monitor: sample on the falling edge, halfway between active edges.
    always @(negedge clock) begin
        logic [8:0] e;
        logic [7:0] ks;
        if (reset) begin
            exp_q.delete();
            model_restart();
            m_in_frame = 0;
            m_frames   = 0;
            exp_err    = 0;
        end else begin
            chk("in_ready", {31'd0, bus.io_in_ready}, {31'd0, (exp_q.size() == 0) || bus.io_out_ready});
            chk("out_valid", {31'd0, bus.io_out_valid}, {31'd0, exp_q.size() != 0});
            chk("sync_err", {31'd0, bus.io_sync_err}, {31'd0, exp_err});
            chk("frame_cnt", {16'd0, bus.io_frame_cnt}, m_frames & 32'hFFFF);
            if (bus.io_sync_err) err_seen++;
            if (bus.io_out_valid && bus.io_out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_data", {24'd0, bus.io_out_data}, {24'd0, e[7:0]});
                chk("out_last", {31'd0, bus.io_out_last}, {31'd0, e[8]});
                last_out = bus.io_out_data;
                cap_q.push_back(bus.io_out_data);
                if (e[8]) m_frames++;
            end
            exp_err = 0;
            if (bus.io_in_valid && bus.io_in_ready) begin
                exp_err = bus.io_in_first ? m_in_frame : !m_in_frame;
                ks = model_ks(bus.io_in_first);
                exp_q.push_back({bus.io_in_last, bus.io_in_data ^ ks});
                m_in_frame = !bus.io_in_last;
            end
        end
    end

    // ---------------- driver tasks ----------------
    bit rand_mode = 0;

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_mode) bus.io_out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] d, input bit first, input bit last);
        bit ok;
        bus.io_in_data  = d;
        bus.io_in_first = first;
        bus.io_in_last  = last;
        bus.io_in_valid = 1'b1;
        ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clock);
            if (bus.io_in_ready) ok = 1;
            tick();
        end
        bus.io_in_valid = 1'b0;
        bus.io_in_data  = 8'($urandom);
        bus.io_in_first = 1'($urandom);
        bus.io_in_last  = 1'($urandom);
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset            = 1'b1;
        bus.io_in_valid  = 1'b0;
        bus.io_in_data   = 8'h00;
        bus.io_in_first  = 1'b0;
        bus.io_in_last   = 1'b0;
        bus.io_out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // reset state
        @(negedge clock);
        chk("rst_out_valid", {31'd0, bus.io_out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, bus.io_out_data}, 32'd0);
        chk("rst_out_last", {31'd0, bus.io_out_last}, 32'd0);
        chk("rst_sync_err", {31'd0, bus.io_sync_err}, 32'd0);
        chk("rst_frame_cnt", {16'd0, bus.io_frame_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.io_in_ready}, 32'd1);
        chk("rst_lfsr", {25'd0, dut.u_lfsr.lfsr}, 32'h7F);
        chk("rst_state", {31'd0, bus.dbg_state}, 32'd0);
        tick();

        // two-byte frame that descrambles to zeros
        cap_q.delete();
        send(8'h70, 1, 0);
        send(8'h4F, 0, 1);
        idle(2);
        chk("t1_n", cap_q.size(), 32'd2);
        chk("t1_b0", {24'd0, cap_q[0]}, 32'h00);
        chk("t1_b1", {24'd0, cap_q[1]}, 32'h00);
        chk("t1_cnt", {16'd0, bus.io_frame_cnt}, 32'd1);
        chk("t1_lfsr", {25'd0, dut.u_lfsr.lfsr}, 32'h72);

        // zeros reveal the raw keystream
        cap_q.delete();
        send(8'h00, 1, 0);
        send(8'h00, 0, 1);
        idle(2);
        chk("t2_b0", {24'd0, cap_q[0]}, 32'h70);
        chk("t2_b1", {24'd0, cap_q[1]}, 32'h4F);
        chk("t2_cnt", {16'd0, bus.io_frame_cnt}, 32'd2);

        // backpressure
        send(8'h70, 1, 0);
        bus.io_out_ready = 1'b0;
        bus.io_in_data   = 8'h4F;
        bus.io_in_first  = 1'b0;
        bus.io_in_last   = 1'b1;
        bus.io_in_valid  = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("bp_in_ready", {31'd0, bus.io_in_ready}, 32'd0);
            chk("bp_valid", {31'd0, bus.io_out_valid}, 32'd1);
            chk("bp_data", {24'd0, bus.io_out_data}, 32'h00);
            chk("bp_lfsr", {25'd0, dut.u_lfsr.lfsr}, 32'h0E);
            tick();
        end
        bus.io_out_ready = 1'b1;
        send(8'h4F, 0, 1);
        idle(2);
        chk("bp_last_out", {24'd0, last_out}, 32'h00);
        chk("bp_cnt", {16'd0, bus.io_frame_cnt}, 32'd3);

        // back-to-back single-byte frames
        cap_q.delete();
        err_seen = 0;
        send(8'h70, 1, 1);
        send(8'h70, 1, 1);
        idle(2);
        chk("t4_b0", {24'd0, cap_q[0]}, 32'h00);
        chk("t4_b1", {24'd0, cap_q[1]}, 32'h00);
        chk("t4_cnt", {16'd0, bus.io_frame_cnt}, 32'd5);
        chk("t4_no_err", err_seen, 32'd0);

        // reset while a byte is pending mid-frame
        send(8'h70, 1, 0);
        bus.io_out_ready = 1'b0;
        pulse_reset();
        @(negedge clock);
        chk("mr_valid", {31'd0, bus.io_out_valid}, 32'd0);
        chk("mr_cnt", {16'd0, bus.io_frame_cnt}, 32'd0);
        chk("mr_in_ready", {31'd0, bus.io_in_ready}, 32'd1);
        tick();
        bus.io_out_ready = 1'b1;
        cap_q.delete();
        send(8'h70, 1, 1);
        idle(2);
        chk("mr_b0", {24'd0, cap_q[0]}, 32'h00);

        // framing violations
        pulse_reset();
        cap_q.delete();
        err_seen = 0;
        send(8'h00, 0, 0);
        send(8'h70, 1, 0);
        send(8'h55, 0, 1);
        idle(3);
        chk("se_count", err_seen, 32'd2);
        chk("se_b0", {24'd0, cap_q[0]}, 32'h70);
        chk("se_b1", {24'd0, cap_q[1]}, 32'h00);

        // randomized traffic with random output stalls
        rand_mode = 1;
        for (int i = 0; i < 400; i++) begin
            send(8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        rand_mode = 0;
        bus.io_out_ready = 1'b1;
        idle(5);
        chk("drain_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "time limit");
    end
endmodule
